// File: rtl/tm_shiftreg_pkg.sv
// Shared definitions for the TM shift-register config path (combiner and splitter).
// Holds the one-hot state encodings, the config word width and the word-count helper.
package tm_shiftreg_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_SEND = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  // Number of WORD_W-bit words needed to cover a data_width-bit vector.
  function automatic int calc_nwords(input int data_width);
    return (data_width + WORD_W - 1) / WORD_W;
  endfunction

endpackage

// File: rtl/config_data_split.sv
// Snapshots a wide TM readback word on pulse and streams it out as 16-bit words,
// word 0 = data_in[15:0], over a valid/ready handshake.
module config_data_split
  import tm_shiftreg_pkg::*;
#(
  parameter int DATA_WIDTH = 170,
  parameter int CNT_WIDTH  = 8,
  parameter int NWORDS     = calc_nwords(DATA_WIDTH)
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pulse,
  output logic [15:0]           data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int TMP_W = NWORDS * WORD_W;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NWORDS - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [TMP_W-1:0]       r_data_tmp;
  logic [CNT_WIDTH-1:0]   r_counter;
  logic [WORD_W-1:0]      r_data_out;
  logic                   r_overrun;

  logic                   w_in_send;
  logic                   w_handshake;
  logic                   w_last;
  logic                   w_accept;
  logic                   w_overrun_set;
  logic [CNT_WIDTH-1:0]   w_next_idx;
  logic [WORD_W-1:0]      w_next_word;
  logic [TMP_W-1:0]       w_data_ext;

  assign w_data_ext  = TMP_W'(data_in);
  assign w_in_send   = (r_state == ST_SEND);
  assign w_handshake = w_in_send & data_ready;
  assign w_last      = (r_counter == LAST_IDX);
  assign w_next_idx  = r_counter + 1'b1;
  // Pre-select the following word so data_out stays a plain register.
  assign w_next_word = r_data_tmp[int'(w_next_idx) * WORD_W +: WORD_W];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A pulse arriving in DONE starts the next snapshot directly, giving the
  // NWORDS+1 cycle minimum pulse period; only a pulse during SEND is an overrun.
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_overrun_set = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (pulse) begin
          w_state_next = ST_SEND;
          w_accept     = 1'b1;
        end
      end
      ST_SEND: begin
        w_overrun_set = pulse;
        if (w_handshake && w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (pulse) begin
          w_state_next = ST_SEND;
          w_accept     = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_data_tmp <= '0;
      r_counter  <= '0;
      r_data_out <= '0;
    end else if (w_accept) begin
      r_data_tmp <= w_data_ext;
      r_counter  <= '0;
      r_data_out <= w_data_ext[WORD_W-1:0];
    end else if (r_state == ST_DONE) begin
      r_data_tmp <= '0;
      r_counter  <= '0;
      r_data_out <= '0;
    end else if (w_handshake && !w_last) begin
      r_counter  <= w_next_idx;
      r_data_out <= w_next_word;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = w_in_send;
  assign busy       = w_in_send;
  assign done       = (r_state == ST_DONE);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_config_data_split.sv
// Scoreboard bench for config_data_split: expected words are queued when a pulse is
// driven and popped on each handshake; inputs driven and outputs sampled on the falling edge.
module tb_config_data_split;

  localparam int DW = 170;
  localparam int NW = 11;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          pulse;
  logic          data_ready;
  logic [15:0]   data_out;
  logic          data_valid;
  logic          busy;
  logic          done;
  logic          overrun;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  config_data_split #(.DATA_WIDTH(DW), .CNT_WIDTH(8)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .pulse     (pulse),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  function automatic logic [DW-1:0] make_vec(input logic [15:0] base, input logic [9:0] top);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < 10; k++) v[16*k +: 16] = base + 16'(k);
    v[169:160] = top;
    return v;
  endfunction

  task automatic push_words(input logic [15:0] base, input logic [9:0] top);
    for (int k = 0; k < 10; k++) exp_q.push_back(base + 16'(k));
    exp_q.push_back({6'h00, top});
  endtask

  task automatic fire_pulse();
    @(negedge clk_in); pulse = 1'b1;
    @(negedge clk_in); pulse = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pulse = 1'b0; data_ready = 1'b0; data_in = '0;
    #12;
    checks++;
    if (data_out !== 16'h0000 || data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got out=%h v=%b b=%b d=%b o=%b required out=0000 v=0 b=0 d=0 o=0",
               data_out, data_valid, busy, done, overrun);
    end
    @(negedge clk_in); rst_n = 1'b1;
    idle_cycles(2);
    $display("test_reset: out=%h valid=%b busy=%b", data_out, data_valid, busy);
  endtask

  task automatic test_basic();
    int busy_cnt = 0, done_cnt = 0, first_hs = -1, last_hs = -1, done_at = -1;
    logic [15:0] exp;
    data_in = make_vec(16'hA000, 10'h3FF); data_ready = 1'b1;
    push_words(16'hA000, 10'h3FF);
    fire_pulse();
    for (int i = 0; i < 16; i++) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = i; end
      if (data_valid && data_ready) begin
        if (first_hs < 0) first_hs = i;
        last_hs = i;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL basic_extra_word got=%h required=none", data_out);
        end else begin
          exp = exp_q.pop_front();
          if (data_out !== exp) begin failures++; $display("FAIL basic_word got=%h required=%h", data_out, exp); end
        end
      end
      @(negedge clk_in);
    end
    checks++;
    if (first_hs != 0) begin failures++; $display("FAIL basic_latency got=%0d required=0", first_hs); end
    checks++;
    if (last_hs - first_hs != NW - 1) begin failures++; $display("FAIL basic_consecutive got=%0d required=%0d", last_hs - first_hs, NW - 1); end
    checks++;
    if (busy_cnt != NW) begin failures++; $display("FAIL basic_busy_cycles got=%0d required=%0d", busy_cnt, NW); end
    checks++;
    if (done_cnt != 1 || done_at != last_hs + 1) begin
      failures++; $display("FAIL basic_done got count=%0d at=%0d required count=1 at=%0d", done_cnt, done_at, last_hs + 1);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL basic_missing_words got=%0d required=0", exp_q.size()); end
    $display("test_basic: busy_cycles=%0d done_at=%0d", busy_cnt, done_at);
  endtask

  task automatic test_backpressure();
    logic held_valid = 1'b0;
    logic [15:0] held, exp;
    logic done_seen = 1'b0;
    int words = 0;
    data_in = make_vec(16'hA000, 10'h3FF);
    push_words(16'hA000, 10'h3FF);
    fire_pulse();
    for (int i = 0; i < 80 && !done_seen; i++) begin
      data_ready = (i % 4 == 0) || (i % 4 == 3);
      if (done) done_seen = 1'b1;
      if (held_valid) begin
        checks++;
        if (data_out !== held || data_valid !== 1'b1) begin
          failures++; $display("FAIL bp_hold got=%h v=%b required=%h v=1", data_out, data_valid, held);
        end
      end
      held_valid = 1'b0;
      if (data_valid) begin
        if (data_ready) begin
          words++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL bp_extra_word got=%h required=none", data_out);
          end else begin
            exp = exp_q.pop_front();
            if (data_out !== exp) begin failures++; $display("FAIL bp_word got=%h required=%h", data_out, exp); end
          end
        end else begin
          held_valid = 1'b1; held = data_out;
        end
      end
      @(negedge clk_in);
    end
    data_ready = 1'b1;
    checks++;
    if (!done_seen || exp_q.size() != 0) begin
      failures++; $display("FAIL bp_complete got done=%b left=%0d required done=1 left=0", done_seen, exp_q.size());
    end
    $display("test_backpressure: words=%0d done=%b", words, done_seen);
    idle_cycles(2);
  endtask

  task automatic test_snapshot();
    logic [15:0] exp;
    int words = 0;
    data_in = make_vec(16'hA000, 10'h3FF); data_ready = 1'b1;
    push_words(16'hA000, 10'h3FF);
    fire_pulse();
    data_in = '1;
    for (int i = 0; i < 14; i++) begin
      if (data_valid && data_ready) begin
        words++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL snap_extra_word got=%h required=none", data_out);
        end else begin
          exp = exp_q.pop_front();
          if (data_out !== exp) begin failures++; $display("FAIL snap_word got=%h required=%h", data_out, exp); end
        end
      end
      @(negedge clk_in);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL snap_missing_words got=%0d required=0", exp_q.size()); end
    $display("test_snapshot: words=%0d", words);
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    int done_cnt = 0, pulse_at = -1, words = 0;
    data_in = make_vec(16'hA000, 10'h3FF); data_ready = 1'b1;
    push_words(16'hA000, 10'h3FF);
    fire_pulse();
    for (int i = 0; i < 40 && done_cnt < 2; i++) begin
      pulse = 1'b0;
      if (i == pulse_at + 1 && pulse_at >= 0) begin
        checks++;
        if (data_valid !== 1'b1 || busy !== 1'b1) begin
          failures++; $display("FAIL b2b_restart got v=%b b=%b required v=1 b=1", data_valid, busy);
        end
      end
      if (data_valid && data_ready) begin
        words++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_extra_word got=%h required=none", data_out);
        end else begin
          exp = exp_q.pop_front();
          if (data_out !== exp) begin failures++; $display("FAIL b2b_word got=%h required=%h", data_out, exp); end
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          data_in = make_vec(16'hB000, 10'h155);
          push_words(16'hB000, 10'h155);
          pulse = 1'b1;
          pulse_at = i;
        end
      end
      @(negedge clk_in);
    end
    pulse = 1'b0;
    checks++;
    if (done_cnt != 2 || exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_complete got dones=%0d left=%0d required dones=2 left=0", done_cnt, exp_q.size());
    end
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b required=0", overrun); end
    $display("test_back_to_back: words=%0d dones=%0d", words, done_cnt);
    idle_cycles(2);
  endtask

  task automatic test_overrun();
    logic [15:0] exp;
    logic done_seen = 1'b0;
    int words = 0;
    data_in = make_vec(16'hA000, 10'h3FF); data_ready = 1'b1;
    push_words(16'hA000, 10'h3FF);
    fire_pulse();
    for (int i = 0; i < 20 && !done_seen; i++) begin
      pulse = 1'b0;
      if (done) done_seen = 1'b1;
      if (i == 5) begin
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b required=0", overrun); end
        data_in = make_vec(16'h5555, 10'h000);
        pulse = 1'b1;
      end
      if (data_valid && data_ready) begin
        words++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL ovr_extra_word got=%h required=none", data_out);
        end else begin
          exp = exp_q.pop_front();
          if (data_out !== exp) begin failures++; $display("FAIL ovr_word got=%h required=%h", data_out, exp); end
        end
      end
      @(negedge clk_in);
    end
    pulse = 1'b0;
    checks++;
    if (!done_seen || exp_q.size() != 0) begin
      failures++; $display("FAIL ovr_complete got done=%b left=%0d required done=1 left=0", done_seen, exp_q.size());
    end
    idle_cycles(4);
    checks++;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      failures++; $display("FAIL ovr_no_restart got b=%b v=%b required b=0 v=0", busy, data_valid);
    end
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b required=1", overrun); end
    $display("test_overrun: words=%0d overrun=%b", words, overrun);
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    int words = 0;
    data_in = make_vec(16'hA000, 10'h3FF); data_ready = 1'b1;
    push_words(16'hA000, 10'h3FF);
    fire_pulse();
    for (int i = 0; i < 4; i++) begin
      if (data_valid && data_ready) begin
        checks++;
        exp = exp_q.pop_front();
        if (data_out !== exp) begin failures++; $display("FAIL rst_pre_word got=%h required=%h", data_out, exp); end
      end
      if (i < 3) @(negedge clk_in);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 16'h0000 || data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state got out=%h v=%b b=%b d=%b o=%b required out=0000 v=0 b=0 d=0 o=0",
               data_out, data_valid, busy, done, overrun);
    end
    exp_q.delete();
    @(negedge clk_in); rst_n = 1'b1;
    idle_cycles(2);
    data_in = make_vec(16'hC000, 10'h2AA);
    push_words(16'hC000, 10'h2AA);
    fire_pulse();
    for (int i = 0; i < 14; i++) begin
      if (data_valid && data_ready) begin
        words++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rst_extra_word got=%h required=none", data_out);
        end else begin
          exp = exp_q.pop_front();
          if (data_out !== exp) begin failures++; $display("FAIL rst_word got=%h required=%h", data_out, exp); end
        end
      end
      @(negedge clk_in);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rst_missing_words got=%0d required=0", exp_q.size()); end
    $display("test_reset_mid: restart words=%0d", words);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
